// File: rtl/id_exe_stage.sv
// ID->EXE pipeline register with MEM/WB operand forwarding, load-use
// hazard detection and bubble insertion for the 5-stage core.

package defines;
  localparam int WORD_LEN = 32;

  // ALU operation select; EXE_ADD is the idle/bubble command.
  typedef enum logic [3:0] {
    EXE_ADD  = 4'd0,
    EXE_SUB  = 4'd1,
    EXE_AND  = 4'd2,
    EXE_OR   = 4'd3,
    EXE_XOR  = 4'd4,
    EXE_SLL  = 4'd5,
    EXE_SRL  = 4'd6,
    EXE_SRA  = 4'd7,
    EXE_SLT  = 4'd8,
    EXE_SLTU = 4'd9,
    EXE_MOV  = 4'd10,
    EXE_NOT  = 4'd11
  } execmd_t;
endpackage

module id_exe_stage #(
  parameter int WORD_LEN   = defines::WORD_LEN,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  defines::execmd_t      id_exe_cmd,
  input  logic [WORD_LEN-1:0]   id_rs1_val,
  input  logic [WORD_LEN-1:0]   id_rs2_val,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic [WORD_LEN-1:0]   id_imm,
  input  logic                  id_use_imm,
  input  logic [REG_ADDR_W-1:0] id_rd_addr,
  input  logic                  id_wb_en,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic                  flush,
  input  logic [REG_ADDR_W-1:0] mem_rd_addr,
  input  logic                  mem_wb_en,
  input  logic                  mem_mem_read,
  input  logic [WORD_LEN-1:0]   mem_aluout,
  input  logic [REG_ADDR_W-1:0] wb_rd_addr,
  input  logic                  wb_wb_en,
  input  logic [WORD_LEN-1:0]   wb_data,
  output logic                  id_stall,
  output logic                  exe_valid,
  output defines::execmd_t      exe_cmd,
  output logic [WORD_LEN-1:0]   val1,
  output logic [WORD_LEN-1:0]   val2,
  output logic [WORD_LEN-1:0]   exe_st_data,
  output logic [REG_ADDR_W-1:0] exe_rd_addr,
  output logic                  exe_wb_en,
  output logic                  exe_mem_read,
  output logic                  exe_mem_write
);

  // EXE-stage pipeline registers
  logic                  valid_reg;
  defines::execmd_t      cmd_reg;
  logic [WORD_LEN-1:0]   rs1_val_reg;
  logic [WORD_LEN-1:0]   rs2_val_reg;
  logic [REG_ADDR_W-1:0] rs1_addr_reg;
  logic [REG_ADDR_W-1:0] rs2_addr_reg;
  logic [WORD_LEN-1:0]   imm_reg;
  logic                  use_imm_reg;
  logic [REG_ADDR_W-1:0] rd_addr_reg;
  logic                  wb_en_reg;
  logic                  mem_read_reg;
  logic                  mem_write_reg;

  logic                  hz;
  logic                  rs1_conflict;
  logic                  rs2_conflict;

  // Per-operand forwarding sources: index 0 is rs1, index 1 is rs2.
  logic [REG_ADDR_W-1:0] src_addr [2];
  logic [WORD_LEN-1:0]   src_val  [2];
  logic [WORD_LEN-1:0]   fwd_val  [2];

  // Load-use hazard: a load in EXE whose rd is consumed by the ID instruction.
  // rs2 only counts when ID actually reads it (register operand or store data).
  always_comb begin
    rs1_conflict = (rd_addr_reg == id_rs1_addr);
    rs2_conflict = (rd_addr_reg == id_rs2_addr) && (!id_use_imm || id_mem_write);
    hz = id_valid && valid_reg && mem_read_reg && (rd_addr_reg != '0) &&
         (rs1_conflict || rs2_conflict);
  end

  // A flush kills the ID instruction anyway, so there is nothing to hold for.
  assign id_stall = hz && !flush;

  // Pipeline register update: reset, flush and load-use all load the same
  // bubble; otherwise capture ID with its enables gated by id_valid.
  always_ff @(posedge clk) begin
    if (!rst_n || flush || hz) begin
      valid_reg     <= 1'b0;
      cmd_reg       <= defines::EXE_ADD;
      rs1_val_reg   <= '0;
      rs2_val_reg   <= '0;
      rs1_addr_reg  <= '0;
      rs2_addr_reg  <= '0;
      imm_reg       <= '0;
      use_imm_reg   <= 1'b0;
      rd_addr_reg   <= '0;
      wb_en_reg     <= 1'b0;
      mem_read_reg  <= 1'b0;
      mem_write_reg <= 1'b0;
    end else begin
      valid_reg     <= id_valid;
      cmd_reg       <= id_exe_cmd;
      rs1_val_reg   <= id_rs1_val;
      rs2_val_reg   <= id_rs2_val;
      rs1_addr_reg  <= id_rs1_addr;
      rs2_addr_reg  <= id_rs2_addr;
      imm_reg       <= id_imm;
      use_imm_reg   <= id_use_imm;
      rd_addr_reg   <= id_rd_addr;
      wb_en_reg     <= id_valid && id_wb_en;
      mem_read_reg  <= id_valid && id_mem_read;
      mem_write_reg <= id_valid && id_mem_write;
    end
  end

  assign src_addr[0] = rs1_addr_reg;
  assign src_addr[1] = rs2_addr_reg;
  assign src_val[0]  = rs1_val_reg;
  assign src_val[1]  = rs2_val_reg;

  // Forwarding muxes: MEM beats WB; x0 and loads still in MEM never forward.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      logic mem_hit;
      logic wb_hit;

      assign mem_hit = mem_wb_en && !mem_mem_read && (mem_rd_addr != '0) &&
                       (mem_rd_addr == src_addr[gi]);
      assign wb_hit  = wb_wb_en && (wb_rd_addr != '0) &&
                       (wb_rd_addr == src_addr[gi]);
      assign fwd_val[gi] = mem_hit ? mem_aluout :
                           wb_hit  ? wb_data    : src_val[gi];
    end
  endgenerate

  assign val1          = fwd_val[0];
  assign val2          = use_imm_reg ? imm_reg : fwd_val[1];
  assign exe_st_data   = fwd_val[1];
  assign exe_valid     = valid_reg;
  assign exe_cmd       = cmd_reg;
  assign exe_rd_addr   = rd_addr_reg;
  assign exe_wb_en     = wb_en_reg && valid_reg;
  assign exe_mem_read  = mem_read_reg && valid_reg;
  assign exe_mem_write = mem_write_reg && valid_reg;

endmodule

// File: tb/tb_id_exe_stage.sv
// Self-checking bench for id_exe_stage: directed scenarios followed by a
// randomized run, all compared against a transaction-level reference model.
module tb_id_exe_stage;
  import defines::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              id_valid;
  execmd_t           id_exe_cmd;
  logic [31:0]       id_rs1_val, id_rs2_val, id_imm;
  logic [4:0]        id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic              id_use_imm, id_wb_en, id_mem_read, id_mem_write;
  logic              flush;
  logic [4:0]        mem_rd_addr, wb_rd_addr;
  logic              mem_wb_en, mem_mem_read, wb_wb_en;
  logic [31:0]       mem_aluout, wb_data;
  logic              id_stall, exe_valid;
  execmd_t           exe_cmd;
  logic [31:0]       val1, val2, exe_st_data;
  logic [4:0]        exe_rd_addr;
  logic              exe_wb_en, exe_mem_read, exe_mem_write;

  int tests_run = 0;
  int fail_cnt  = 0;

  id_exe_stage #(.WORD_LEN(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_exe_cmd(id_exe_cmd),
    .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_imm(id_imm), .id_use_imm(id_use_imm), .id_rd_addr(id_rd_addr),
    .id_wb_en(id_wb_en), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .flush(flush), .mem_rd_addr(mem_rd_addr), .mem_wb_en(mem_wb_en),
    .mem_mem_read(mem_mem_read), .mem_aluout(mem_aluout),
    .wb_rd_addr(wb_rd_addr), .wb_wb_en(wb_wb_en), .wb_data(wb_data),
    .id_stall(id_stall), .exe_valid(exe_valid), .exe_cmd(exe_cmd),
    .val1(val1), .val2(val2), .exe_st_data(exe_st_data),
    .exe_rd_addr(exe_rd_addr), .exe_wb_en(exe_wb_en),
    .exe_mem_read(exe_mem_read), .exe_mem_write(exe_mem_write)
  );

  always #5 clk = ~clk;

  // Reference model: the instruction currently sitting in EXE.
  typedef struct {
    logic        valid;
    execmd_t     cmd;
    logic [31:0] rs1v, rs2v, imm;
    logic [4:0]  rs1a, rs2a, rd;
    logic        use_imm, wb, mr, mw;
  } exe_t;

  exe_t m;

  function automatic exe_t bubble();
    exe_t b;
    b.valid = 1'b0; b.cmd = EXE_ADD;
    b.rs1v = '0; b.rs2v = '0; b.imm = '0;
    b.rs1a = '0; b.rs2a = '0; b.rd = '0;
    b.use_imm = 1'b0; b.wb = 1'b0; b.mr = 1'b0; b.mw = 1'b0;
    return b;
  endfunction

  // Does the ID instruction need a register that a load in EXE has not produced yet?
  function automatic logic model_hazard();
    logic needs_rs1, needs_rs2;
    if (!(id_valid && m.valid && m.mr && m.rd != 0)) return 1'b0;
    needs_rs1 = (id_rs1_addr == m.rd);
    needs_rs2 = (id_rs2_addr == m.rd) && (!id_use_imm || id_mem_write);
    return needs_rs1 || needs_rs2;
  endfunction

  // Newest available value of a register: MEM result, then WB, then RF read.
  function automatic logic [31:0] newest(input logic [4:0] a, input logic [31:0] rf);
    if (a == 0) return rf;
    if (mem_wb_en && !mem_mem_read && mem_rd_addr == a) return mem_aluout;
    if (wb_wb_en && wb_rd_addr == a) return wb_data;
    return rf;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [31:0] e2;
    e2 = newest(m.rs2a, m.rs2v);
    chk({tag, ".stall"}, 64'(id_stall), 64'(model_hazard() && !flush));
    chk({tag, ".valid"}, 64'(exe_valid), 64'(m.valid));
    chk({tag, ".cmd"}, 64'(exe_cmd), 64'(m.cmd));
    chk({tag, ".val1"}, 64'(val1), 64'(newest(m.rs1a, m.rs1v)));
    chk({tag, ".val2"}, 64'(val2), 64'(m.use_imm ? m.imm : e2));
    chk({tag, ".st_data"}, 64'(exe_st_data), 64'(e2));
    chk({tag, ".rd"}, 64'(exe_rd_addr), 64'(m.rd));
    chk({tag, ".wb_en"}, 64'(exe_wb_en), 64'(m.valid && m.wb));
    chk({tag, ".mem_rd"}, 64'(exe_mem_read), 64'(m.valid && m.mr));
    chk({tag, ".mem_wr"}, 64'(exe_mem_write), 64'(m.valid && m.mw));
  endtask

  // One clock: check current outputs, advance model and DUT together.
  task automatic step(input string tag);
    exe_t nxt;
    #1;
    check_outputs(tag);
    if (!rst_n || flush || model_hazard()) begin
      nxt = bubble();
    end else begin
      nxt.valid = id_valid; nxt.cmd = id_exe_cmd;
      nxt.rs1v = id_rs1_val; nxt.rs2v = id_rs2_val; nxt.imm = id_imm;
      nxt.rs1a = id_rs1_addr; nxt.rs2a = id_rs2_addr; nxt.rd = id_rd_addr;
      nxt.use_imm = id_use_imm; nxt.wb = id_wb_en;
      nxt.mr = id_mem_read; nxt.mw = id_mem_write;
    end
    @(posedge clk);
    #1;
    m = nxt;
    $display("[TB] step %-10s valid=%0b cmd=%0d val1=%h val2=%h stall=%0b",
             tag, exe_valid, exe_cmd, val1, val2, id_stall);
  endtask

  task automatic idle_inputs();
    rst_n = 1'b1; id_valid = 1'b0; id_exe_cmd = EXE_ADD;
    id_rs1_val = '0; id_rs2_val = '0; id_imm = '0;
    id_rs1_addr = '0; id_rs2_addr = '0; id_rd_addr = '0;
    id_use_imm = 1'b0; id_wb_en = 1'b0; id_mem_read = 1'b0; id_mem_write = 1'b0;
    flush = 1'b0;
    mem_rd_addr = '0; mem_wb_en = 1'b0; mem_mem_read = 1'b0; mem_aluout = '0;
    wb_rd_addr = '0; wb_wb_en = 1'b0; wb_data = '0;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    @(posedge clk); #1;
    m = bubble();
    rst_n = 1'b1;
    check_outputs("reset");

    // Basic ADD: x1=5, x2=7
    id_valid = 1; id_exe_cmd = EXE_ADD; id_rs1_addr = 1; id_rs1_val = 5;
    id_rs2_addr = 2; id_rs2_val = 7; id_rd_addr = 3; id_wb_en = 1;
    step("basic_in");
    idle_inputs();
    #1;
    chk("basic.valid", 64'(exe_valid), 64'd1);
    chk("basic.val1", 64'(val1), 64'd5);
    chk("basic.val2", 64'(val2), 64'd7);
    step("basic_out");

    // MEM vs WB forwarding priority on rs1=x3
    id_valid = 1; id_exe_cmd = EXE_SUB; id_rs1_addr = 3; id_rs1_val = 32'h99;
    id_rs2_addr = 0; id_rd_addr = 8; id_wb_en = 1;
    step("fwd_in");
    idle_inputs();
    mem_rd_addr = 3; mem_wb_en = 1; mem_aluout = 32'h10;
    wb_rd_addr = 3; wb_wb_en = 1; wb_data = 32'h20;
    #1; chk("fwd.mem_prio", 64'(val1), 64'h10);
    mem_wb_en = 0;
    #1; chk("fwd.wb", 64'(val1), 64'h20);
    mem_wb_en = 1; mem_mem_read = 1;
    #1; chk("fwd.mem_load", 64'(val1), 64'h20);
    step("fwd_out");
    idle_inputs();
    id_valid = 1; id_rs1_addr = 0; id_rs1_val = 32'h77;
    step("x0_in");
    mem_rd_addr = 0; mem_wb_en = 1; mem_aluout = 32'h10;
    wb_rd_addr = 0; wb_wb_en = 1; wb_data = 32'h20;
    #1; chk("fwd.x0", 64'(val1), 64'h77);
    idle_inputs();
    step("x0_out");

    // Load-use on rs2=x4
    id_valid = 1; id_mem_read = 1; id_wb_en = 1; id_rd_addr = 4; id_rs1_addr = 9;
    step("ld_in");
    idle_inputs();
    id_valid = 1; id_exe_cmd = EXE_OR; id_rs1_addr = 1; id_rs1_val = 1;
    id_rs2_addr = 4; id_rs2_val = 32'hDEAD; id_rd_addr = 5; id_wb_en = 1;
    #1; chk("lu.stall", 64'(id_stall), 64'd1);
    step("lu_stall");
    chk("lu.bubble_wb", 64'(exe_wb_en), 64'd0);
    mem_rd_addr = 4; mem_wb_en = 1; mem_mem_read = 1; mem_aluout = 32'h1234;
    step("lu_repres");
    mem_wb_en = 0; mem_mem_read = 0; mem_rd_addr = 0;
    wb_rd_addr = 4; wb_wb_en = 1; wb_data = 32'h55;
    id_valid = 0;
    #1; chk("lu.val2", 64'(val2), 64'h55);
    step("lu_out");
    idle_inputs();

    // Immediate path with rs2 matching a MEM rd
    id_valid = 1; id_use_imm = 1; id_imm = 32'hFFFF_FFF0; id_rs2_addr = 5;
    id_rs2_val = 32'h1; id_mem_write = 1;
    step("imm_in");
    idle_inputs();
    mem_rd_addr = 5; mem_wb_en = 1; mem_aluout = 32'hABCD;
    #1;
    chk("imm.val2", 64'(val2), 64'hFFFF_FFF0);
    chk("imm.st_data", 64'(exe_st_data), 64'hABCD);
    step("imm_out");
    idle_inputs();

    // Disabled ID with enables high must not leak into EXE
    id_valid = 0; id_wb_en = 1; id_mem_read = 1; id_mem_write = 1; id_rd_addr = 7;
    step("inv_in");
    chk("inv.wb_en", 64'(exe_wb_en), 64'd0);
    idle_inputs();

    // Flush together with a load-use hazard, then flush alone
    id_valid = 1; id_mem_read = 1; id_wb_en = 1; id_rd_addr = 6;
    step("fl_ld");
    idle_inputs();
    id_valid = 1; id_rs1_addr = 6; id_wb_en = 1; id_rd_addr = 2; flush = 1;
    #1; chk("fl.stall", 64'(id_stall), 64'd0);
    step("fl_hz");
    chk("fl.valid", 64'(exe_valid), 64'd0);
    id_rs1_addr = 1;
    step("fl_only");
    chk("fl_only.valid", 64'(exe_valid), 64'd0);
    idle_inputs();

    // Reset in the middle of a stream
    id_valid = 1; id_exe_cmd = EXE_XOR; id_rs1_val = 32'h5; id_rd_addr = 9; id_wb_en = 1;
    step("rst_pre");
    chk("rst.pre_valid", 64'(exe_valid), 64'd1);
    rst_n = 0; flush = 1;
    step("rst_edge");
    chk("rst.valid", 64'(exe_valid), 64'd0);
    chk("rst.cmd", 64'(exe_cmd), 64'(EXE_ADD));
    rst_n = 1; flush = 0;
    step("rst_post");
    chk("rst.relatch", 64'(exe_valid), 64'd1);
    idle_inputs();

    // Randomized run: small address space so hazards and forwards are frequent
    for (int i = 0; i < 400; i++) begin
      rst_n        = ($urandom_range(0, 31) != 0);
      flush        = ($urandom_range(0, 7) == 0);
      id_valid     = ($urandom_range(0, 3) != 0);
      id_exe_cmd   = execmd_t'($urandom_range(0, 11));
      id_rs1_val   = $urandom;
      id_rs2_val   = $urandom;
      id_imm       = $urandom;
      id_rs1_addr  = 5'($urandom_range(0, 3));
      id_rs2_addr  = 5'($urandom_range(0, 3));
      id_rd_addr   = 5'($urandom_range(0, 3));
      id_use_imm   = $urandom_range(0, 1) == 1;
      id_wb_en     = $urandom_range(0, 1) == 1;
      id_mem_read  = $urandom_range(0, 1) == 1;
      id_mem_write = $urandom_range(0, 3) == 0;
      mem_rd_addr  = 5'($urandom_range(0, 3));
      mem_wb_en    = $urandom_range(0, 1) == 1;
      mem_mem_read = $urandom_range(0, 3) == 0;
      mem_aluout   = $urandom;
      wb_rd_addr   = 5'($urandom_range(0, 3));
      wb_wb_en     = $urandom_range(0, 1) == 1;
      wb_data      = $urandom;
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
